// File: rtl/odometer_multich_ctrl.sv
// Multi-channel ring-oscillator odometer sequencer: stress, then sweep the masked
// channels measuring beat periods. Define ODO_AVG_EN to average 2^AVG_LOG2 periods.
//
// state  | meaning
// IDLE   | stress off, waiting for START or a sweep request
// STRESS | stress enabled on masked channels (DC or divided AC)
// SETTLE | channel just selected, letting the RO pair settle
// SYNC   | waiting for the first beat edge of the channel
// COUNT  | counting cycles until the closing beat edge
// DONE   | one-cycle gap after the sweep before stress resumes
module odometer_multich_ctrl #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 12,
   parameter int SETTLE_CYC  = 8,
   parameter int TIMEOUT_CYC = 4095,
   parameter int AC_DIV_LOG2 = 0,
   parameter int AVG_LOG2    = 2,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              AC_STRESS_CLK,
   input  logic              RESETB,
   input  logic              LOAD,
   input  logic              START,
   input  logic              AC_DC,
   input  logic [2:0]        SEL_GATE,
   input  logic [NUM_CH-1:0] CH_MASK,
   input  logic              MEAS_TRIG,
   input  logic [NUM_CH-1:0] BEAT_IN,
   output logic [NUM_CH-1:0] STRESS_EN,
   output logic              STRESS_AC,
   output logic [2:0]        STRESS_SEL,
   output logic              MEAS_EN,
   output logic [CH_W-1:0]   CH_SEL,
   output logic [CNT_W-1:0]  BF_COUNT,
   output logic [CH_W-1:0]   BF_CH,
   output logic              BF_VALID,
   output logic              OVF,
   output logic              BUSY
);

   typedef enum logic [2:0] {S_IDLE, S_STRESS, S_SETTLE, S_SYNC, S_COUNT, S_DONE} state_t;

`ifdef ODO_AVG_EN
   localparam int AVG_SH = AVG_LOG2;
`else
   localparam int AVG_SH = 0;
`endif
   localparam int TMR_MAX   = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
   localparam int TMR_W     = $clog2(TMR_MAX + 1);
   localparam int DIV_W     = (AC_DIV_LOG2 > 0) ? AC_DIV_LOG2 : 1;
   localparam int AVG_IDX_W = (AVG_SH > 0) ? AVG_SH : 1;
   localparam int SUM_W     = CNT_W + AVG_SH;
   localparam logic [TMR_W-1:0]     SETTLE_LD  = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0]     TIMEOUT_LD = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]     CNT_MAX    = '1;
   localparam logic [DIV_W-1:0]     DIV_MAX    = DIV_W'((1 << AC_DIV_LOG2) - 1);
   localparam logic [AVG_IDX_W-1:0] AVG_LAST   = AVG_IDX_W'((1 << AVG_SH) - 1);

   state_t                state, state_nxt;
   logic                  ac_dc_q, trig_q, ac_q, ovf_acc;
   logic [2:0]            sel_q;
   logic [NUM_CH-1:0]     mask_q, beat_s1, beat_s2, beat_s3;
   logic [CH_W-1:0]       ch_sel, first_ch, nxt_ch, bf_ch_q;
   logic                  nxt_found;
   logic [TMR_W-1:0]      tmr;
   logic [CNT_W-1:0]      cnt, bf_count_q, rep_cnt;
   logic [DIV_W-1:0]      div_cnt;
   logic [AVG_IDX_W-1:0]  avg_idx;
   logic [SUM_W-1:0]      sum, sum_nxt;
   logic                  bf_valid_q, ovf_q;
   logic                  sweep_req, beat_edge, tmr_zero, cnt_sat, last_period;
   logic                  cfg_we, rep, rep_ovf;

   assign sweep_req   = trig_q & ~MEAS_TRIG & (|mask_q);
   assign beat_edge   = beat_s2[ch_sel] & ~beat_s3[ch_sel];
   assign tmr_zero    = (tmr == '0);
   assign cnt_sat     = (cnt == CNT_MAX);
   assign last_period = (avg_idx == AVG_LAST);
   assign sum_nxt     = sum + SUM_W'(cnt);

   always_comb begin
      first_ch  = '0;
      nxt_ch    = '0;
      nxt_found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_q[i]) first_ch = CH_W'(i);
         if (mask_q[i] && (CH_W'(i) > ch_sel)) begin
            nxt_ch    = CH_W'(i);
            nxt_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      rep       = 1'b0;
      rep_cnt   = CNT_MAX;
      rep_ovf   = 1'b1;
      case (state)
         S_IDLE:   if (sweep_req) state_nxt = S_SETTLE;
                   else if (START) state_nxt = S_STRESS;
         S_STRESS: if (sweep_req) state_nxt = S_SETTLE;
                   else if (!START) state_nxt = S_IDLE;
         S_SETTLE: if (tmr_zero) state_nxt = S_SYNC;
         S_SYNC: begin
            if (beat_edge) state_nxt = S_COUNT;
            else if (tmr_zero) rep = 1'b1;
         end
         S_COUNT: begin
            if (beat_edge) begin
               if (last_period) begin
                  rep     = 1'b1;
                  rep_cnt = CNT_W'(sum_nxt >> AVG_SH);
                  rep_ovf = ovf_acc | cnt_sat;
               end
            end else if (tmr_zero) begin
               rep = 1'b1;
            end
         end
         S_DONE:   state_nxt = START ? S_STRESS : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (rep) state_nxt = nxt_found ? S_SETTLE : S_DONE;
   end

   assign cfg_we     = LOAD && (state == S_IDLE || state == S_STRESS) && (state_nxt != S_SETTLE);
   assign STRESS_EN  = (state == S_STRESS) ? mask_q : '0;
   assign STRESS_AC  = (state == S_STRESS && ac_dc_q) ? ac_q : 1'b1;
   assign STRESS_SEL = sel_q;
   assign MEAS_EN    = (state == S_SETTLE) || (state == S_SYNC) || (state == S_COUNT);
   assign BUSY       = (state != S_IDLE) && (state != S_STRESS);
   assign CH_SEL     = ch_sel;
   assign BF_COUNT   = bf_count_q;
   assign BF_CH      = bf_ch_q;
   assign BF_VALID   = bf_valid_q;
   assign OVF        = ovf_q;

   always_ff @(posedge AC_STRESS_CLK) begin
      if (!RESETB) begin
         state      <= S_IDLE;
         ac_dc_q    <= 1'b0;
         sel_q      <= '0;
         mask_q     <= '0;
         trig_q     <= 1'b1;
         beat_s1    <= '0;
         beat_s2    <= '0;
         beat_s3    <= '0;
         ch_sel     <= '0;
         tmr        <= '0;
         cnt        <= '0;
         div_cnt    <= '0;
         ac_q       <= 1'b1;
         avg_idx    <= '0;
         sum        <= '0;
         ovf_acc    <= 1'b0;
         bf_count_q <= '0;
         bf_ch_q    <= '0;
         bf_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state   <= state_nxt;
         trig_q  <= MEAS_TRIG;
         beat_s1 <= BEAT_IN;
         beat_s2 <= beat_s1;
         beat_s3 <= beat_s2;
         if (cfg_we) begin
            ac_dc_q <= AC_DC;
            sel_q   <= SEL_GATE;
            mask_q  <= CH_MASK;
         end
         bf_valid_q <= rep;
         if (rep) begin
            bf_count_q <= rep_cnt;
            bf_ch_q    <= ch_sel;
            ovf_q      <= rep_ovf;
         end
         // AC waveform restarts high with a fresh divider on every STRESS entry
         if (state_nxt == S_STRESS && state != S_STRESS) begin
            div_cnt <= '0;
            ac_q    <= 1'b1;
         end else if (state == S_STRESS) begin
            if (div_cnt == DIV_MAX) begin
               div_cnt <= '0;
               ac_q    <= ~ac_q;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end
         case (state)
            S_IDLE, S_STRESS: begin
               if (state_nxt == S_SETTLE) begin
                  ch_sel <= first_ch;
                  tmr    <= SETTLE_LD;
               end
            end
            S_SETTLE: tmr <= tmr_zero ? TIMEOUT_LD : tmr - 1'b1;
            S_SYNC: begin
               tmr <= beat_edge ? TIMEOUT_LD : tmr - 1'b1;
               if (beat_edge) begin
                  cnt     <= CNT_W'(1);
                  sum     <= '0;
                  avg_idx <= '0;
                  ovf_acc <= 1'b0;
               end
            end
            S_COUNT: begin
               if (beat_edge) begin
                  cnt     <= CNT_W'(1);
                  tmr     <= TIMEOUT_LD;
                  sum     <= sum_nxt;
                  avg_idx <= avg_idx + 1'b1;
                  ovf_acc <= ovf_acc | cnt_sat;
               end else begin
                  cnt <= cnt_sat ? cnt : cnt + 1'b1;
                  tmr <= tmr - 1'b1;
               end
            end
            default: ;
         endcase
         if (rep && nxt_found) begin
            ch_sel <= nxt_ch;
            tmr    <= SETTLE_LD;
         end
      end
   end

endmodule

// File: doc/odometer_multich_ctrl.md
Name: odometer_multich_ctrl

Overview:
- Parametrised successor to the single-channel odometer control: sequences stress and measure over NUM_CH ring-oscillator channels.
- Produces a CNT_W-bit beat-frequency count per channel.
- Sits between the scan/pad configuration inputs and the per-channel stressed/reference RO pairs. Each pair supplies a beat signal from its phase comparator.
- Adds channel masking, programmable AC stress rate, settle time, beat timeout and count saturation.

Parameters:
- NUM_CH, 4, number of RO channels (1..16).
- CNT_W, 12, beat-count width.
- SETTLE_CYC, 8, cycles after a channel switch before beat sync starts (>=1).
- TIMEOUT_CYC, 4095, max cycles waiting for a beat edge in SYNC or COUNT.
- AC_DIV_LOG2, 0, AC stress toggle period is 2^AC_DIV_LOG2 cycles.
- AVG_LOG2, 2, averaging depth; used only with ODO_AVG_EN.

Ports:
- AC_STRESS_CLK  in  1  sole clock, rising edge.
- RESETB  in  1  reset; synchronous, active-low.
- LOAD  in  1  config capture enable.
- START  in  1  1 = stress enabled while not measuring.
- AC_DC  in  1  0 = DC stress, 1 = AC stress.
- SEL_GATE  in  3  one-hot gate type {NOR,NAND,INV}; passed through to STRESS_SEL.
- CH_MASK  in  NUM_CH  channel enables.
- MEAS_TRIG  in  1  falling edge requests a measurement sweep.
- BEAT_IN  in  NUM_CH  asynchronous per-channel beat signals.
- STRESS_EN  out  NUM_CH  per-channel stress enable.
- STRESS_AC  out  1  AC stress waveform; 1 in DC mode.
- STRESS_SEL  out  3  registered SEL_GATE.
- MEAS_EN  out  1  high for the whole sweep.
- CH_SEL  out  clog2(NUM_CH), min 1  channel being measured.
- BF_COUNT  out  CNT_W  last result.
- BF_CH  out  clog2(NUM_CH)  channel of the last result.
- BF_VALID  out  1  one-cycle result strobe.
- OVF  out  1  last result saturated or timed out.
- BUSY  out  1  state not IDLE/STRESS.

Behaviour:
- Reset (RESETB=0 at a clock edge):
  - All outputs 0, except STRESS_AC=1.
  - State = IDLE; config registers cleared; the MEAS_TRIG edge register is set to 1.
- Config capture: AC_DC, SEL_GATE and CH_MASK are registered on any cycle with LOAD=1 and state IDLE or STRESS. LOAD is ignored while BUSY.
- Input synchronisation:
  - BEAT_IN passes through a 2-flop synchroniser per channel.
  - A beat edge is a 0->1 transition of the synchronised bit of the channel selected by CH_SEL.
- MEAS_TRIG edge: detected as registered 1 followed by current 0.
- States:
  - IDLE: STRESS_EN=0.
    - START=1 -> STRESS.
    - Falling edge of MEAS_TRIG -> SETTLE.
  - STRESS: STRESS_EN = CH_MASK.
    - START=0 -> IDLE.
    - Falling edge of MEAS_TRIG -> SETTLE.
  - SETTLE: STRESS_EN=0, MEAS_EN=1, CH_SEL = lowest unmeasured masked channel.
    - Waits SETTLE_CYC cycles -> SYNC.
  - SYNC: wait for a beat edge.
    - On the edge, clear the counter -> COUNT.
  - COUNT: counter increments each cycle.
    - On the next beat edge: BF_COUNT = cycles between the two edges, BF_CH = CH_SEL, BF_VALID=1 for one cycle.
    - If more masked channels remain -> SETTLE (next higher channel), else -> DONE.
  - DONE: MEAS_EN=0 for one cycle.
    - Then -> STRESS if START=1, else IDLE.
- Transition timing:
  - The edge registered at clock t gives SETTLE (MEAS_EN=1, STRESS_EN=0) at t+1.
  - A beat period of P cycles gives BF_COUNT=P.
- Boundary rules:
  - CH_MASK=0: MEAS_TRIG is ignored; stress stays off.
  - Count reaches 2^CNT_W-1: it saturates. The result is reported with OVF=1.
  - No beat edge within TIMEOUT_CYC cycles in SYNC or COUNT: BF_COUNT = all ones, OVF=1, BF_VALID pulses, then the sweep advances.
  - MEAS_TRIG edges while BUSY are ignored.
  - START changes while BUSY take effect only in DONE.
  - RESETB=0 mid-sweep: abort immediately. No BF_VALID is issued.
- AC stress:
  - AC_DC=1 in STRESS: STRESS_AC toggles every 2^AC_DIV_LOG2 cycles. A free-running divider counter is cleared on entering STRESS.
  - Otherwise STRESS_AC=1.

Optional Feature:
- Macro ODO_AVG_EN.
- Defined:
  - COUNT accumulates 2^AVG_LOG2 consecutive beat periods in a (CNT_W+AVG_LOG2)-bit sum.
  - BF_COUNT = sum >> AVG_LOG2, truncated.
  - The timeout applies per beat period.
  - OVF is set if any period saturated or timed out. A timeout ends the channel immediately.
- Undefined: a single period is measured; AVG_LOG2 is unused.

Test Plan:
- NUM_CH=4, CH_MASK=4'hF, START=1, AC_DC=0: STRESS_EN=4'hF, STRESS_AC=1. MEAS_TRIG 1->0 -> next cycle STRESS_EN=0, MEAS_EN=1. Beat periods 37/50/64/100 -> four BF_VALID strobes with BF_CH 0..3, BF_COUNT 37/50/64/100, OVF=0. Then STRESS resumes.
- CH_MASK=4'b1010 -> only BF_CH=1 then BF_CH=3. CH_MASK=0 plus MEAS_TRIG -> no BUSY, no BF_VALID.
- Channel 2 beat held at 0, TIMEOUT_CYC=100 -> BF_COUNT=12'hFFF, OVF=1 on BF_CH=2. Channel 3 is still measured.
- CNT_W=6, beat period 80 -> BF_COUNT=63, OVF=1.
- AC_DC=1, AC_DIV_LOG2=1 -> STRESS_AC toggles every 2 cycles. LOAD=1 with new CH_MASK during a sweep -> unchanged until DONE.
- RESETB=0 during COUNT -> next cycle all outputs reset, no BF_VALID. A re-trigger after release is measured normally.
